pad_reader_multi: RTL and testbench
===================================

PAD_READER_MULTI -- requirements
Module: pad_reader_multi

Interface
REQ-001 Parameter NUM_PADS, default 2, number of controller ports sharing latch and pad_clk (1..4).
REQ-002 Parameter NUM_BITS, default 8, serial bits per frame (8 = NES, 16 = SNES).
REQ-003 Parameter LATCH_CYCLES, default 600, latch high time in clk cycles (12 us at 50 MHz).
REQ-004 Parameter HALF_CYCLES, default 300, pad_clk half-period in clk cycles (6 us at 50 MHz).
REQ-005 Parameter POLL_CYCLES, default 833333, latch-rise to latch-rise period in clk cycles (~60 Hz).
REQ-006 clk  input  1  system clock; all logic is on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 enable  input  1  polling enable; level-sensitive.
REQ-009 data  input  NUM_PADS  serial data from each pad, active-low (0 = pressed).
REQ-010 latch  output  1  shared latch strobe to all pads, active-high.
REQ-011 pad_clk  output  1  shared shift clock to all pads, idles low.
REQ-012 buttons  output  NUM_PADS*NUM_BITS  registered button state, active-high; pad p bit i at index p*NUM_BITS+i.
REQ-013 pressed  output  NUM_PADS*NUM_BITS  one-cycle pulse per button on 0->1 transition of buttons.
REQ-014 released  output  NUM_PADS*NUM_BITS  one-cycle pulse per button on 1->0 transition of buttons.
REQ-015 valid  output  1  one-cycle pulse when buttons is updated.

Function
REQ-016 FSM states SHALL be IDLE, LATCH, LOW, HIGH, DONE, WAIT.
REQ-017 IDLE: outputs static; enable=1 -> LATCH on the next edge.
REQ-018 LATCH: latch=1 for exactly LATCH_CYCLES cycles, then LOW with bit index 0.
REQ-019 LOW: pad_clk=0 for HALF_CYCLES cycles; on the last cycle each data[p] SHALL be sampled, inverted, and stored to shift bit i of pad p.
REQ-020 After LOW: if i < NUM_BITS-1 -> HIGH; else -> DONE.
REQ-021 HIGH: pad_clk=1 for HALF_CYCLES cycles, then i increments and -> LOW; one frame therefore has exactly NUM_BITS-1 pad_clk pulses.
REQ-022 Bit order for NUM_BITS=8: i = 0..7 is A, B, Select, Start, Up, Down, Left, Right.
REQ-023 DONE (one cycle): buttons <= shift register; pressed <= new & ~old; released <= ~new & old; valid=1; all pads update in the same cycle.
REQ-024 pressed, released and valid SHALL be 0 in every cycle other than the cycle after DONE; buttons SHALL be held between frames.
REQ-025 WAIT: free-running poll counter started at latch rise; when POLL_CYCLES cycles have elapsed since that rise and enable=1 -> LATCH.
REQ-026 If POLL_CYCLES is shorter than the frame length, the next LATCH SHALL start immediately after DONE.
REQ-027 enable=0 mid-frame: the frame SHALL complete, including its valid pulse, then -> IDLE with no further latch.
REQ-028 enable=0 in WAIT -> IDLE; a later enable=1 SHALL start LATCH on the next edge without waiting for the poll counter.
REQ-029 Counters SHALL be sized from the parameters (clog2) with no wrap inside a phase.

Reset
REQ-030 While reset=1: latch=0, pad_clk=0, buttons=0, pressed=0, released=0, valid=0, state IDLE, all counters and shift register 0.
REQ-031 Reset mid-frame SHALL abort the frame immediately; no valid pulse for the aborted frame.
REQ-032 After reset deasserts, the block SHALL remain in IDLE until it samples enable=1.

Verification (bench parameters: NUM_PADS=2, NUM_BITS=8, LATCH_CYCLES=4, HALF_CYCLES=2, POLL_CYCLES=100)
REQ-033 Reset, then enable=1 -> latch high exactly 4 cycles starting one edge later; then 7 pad_clk pulses, each 2 cycles high and 2 cycles low; all outputs 0 before this.
REQ-034 Pad0 data low at bits 0 and 3, pad1 all high -> buttons = 16'h0009; pressed = 16'h0009 for one cycle with valid; second latch rise exactly 100 cycles after the first.
REQ-035 Same pattern next frame -> valid pulses, pressed=0, released=0, buttons unchanged; third frame with pad0 bit 0 high -> released = 16'h0001 pulse, buttons = 16'h0008.
REQ-036 Pad1 all low -> buttons[15:8] = 8'hFF, pressed[15:8] = 8'hFF; pad0 bits unaffected.
REQ-037 Reset asserted during HIGH of bit 4 -> all outputs 0 asynchronously, no valid pulse; after release no latch until enable is sampled 1.
REQ-038 enable dropped during LATCH -> frame completes with one valid pulse, then latch stays 0 for at least 200 cycles; repeat with NUM_BITS=16 -> 15 pad_clk pulses and 32-bit buttons.

Source files
------------

// File: rtl/pad_reader_multi.sv
// NES/SNES controller poller: drives a shared latch/pad_clk to NUM_PADS pads, shifts in
// their serial data and publishes registered button state with press/release edge pulses.
module pad_reader_multi #(
    parameter int unsigned NUM_PADS     = 2,
    parameter int unsigned NUM_BITS     = 8,
    parameter int unsigned LATCH_CYCLES = 600,
    parameter int unsigned HALF_CYCLES  = 300,
    parameter int unsigned POLL_CYCLES  = 833333
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_PADS-1:0]          data,
    output logic                         latch,
    output logic                         pad_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic [NUM_PADS*NUM_BITS-1:0] released,
    output logic                         valid
);

    localparam int unsigned PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned CW = $clog2(PHASE_MAX + 1);
    localparam int unsigned IW = $clog2(NUM_BITS + 1);
    localparam int unsigned PW = $clog2(POLL_CYCLES + 1);

    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
    localparam logic [IW-1:0] BIT_LAST   = IW'(NUM_BITS - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE, WAIT} state_t;

    state_t                        state;
    logic [CW-1:0]                 phase_cnt;
    logic [IW-1:0]                 bit_idx;
    logic [PW-1:0]                 poll_cnt;
    logic [NUM_PADS*NUM_BITS-1:0]  shift_flat;
    logic                          sample;
    logic                          poll_due;
    logic                          start;

    assign sample   = (state == LOW) && (phase_cnt == HALF_LAST);
    assign poll_due = (poll_cnt == POLL_LAST);
    // A new frame begins from IDLE immediately, or after DONE/WAIT once the poll period has elapsed.
    assign start    = enable && ((state == IDLE) ||
                                 (((state == DONE) || (state == WAIT)) && poll_due));

    // Each pad shifts in at the MSB, so after NUM_BITS samples the first bit sits at index 0.
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [NUM_BITS-1:0] sreg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sreg <= '0;
            end else if (sample) begin
                sreg <= {~data[p], sreg[NUM_BITS-1:1]};
            end
        end

        assign shift_flat[p*NUM_BITS +: NUM_BITS] = sreg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            bit_idx   <= '0;
            poll_cnt  <= '0;
            latch     <= 1'b0;
            pad_clk   <= 1'b0;
            buttons   <= '0;
            pressed   <= '0;
            released  <= '0;
            valid     <= 1'b0;
        end else begin
            pressed  <= '0;
            released <= '0;
            valid    <= 1'b0;

            if (!poll_due) begin
                poll_cnt <= poll_cnt + PW'(1);
            end

            if (state == DONE) begin
                buttons  <= shift_flat;
                pressed  <= shift_flat & ~buttons;
                released <= ~shift_flat & buttons;
                valid    <= 1'b1;
            end

            if (start) begin
                state     <= LATCH;
                latch     <= 1'b1;
                phase_cnt <= '0;
                poll_cnt  <= '0;
            end else begin
                case (state)
                    LATCH: begin
                        if (phase_cnt == LATCH_LAST) begin
                            state     <= LOW;
                            latch     <= 1'b0;
                            phase_cnt <= '0;
                            bit_idx   <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + CW'(1);
                        end
                    end
                    LOW: begin
                        if (phase_cnt == HALF_LAST) begin
                            phase_cnt <= '0;
                            if (bit_idx == BIT_LAST) begin
                                state <= DONE;
                            end else begin
                                state   <= HIGH;
                                pad_clk <= 1'b1;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + CW'(1);
                        end
                    end
                    HIGH: begin
                        if (phase_cnt == HALF_LAST) begin
                            state     <= LOW;
                            pad_clk   <= 1'b0;
                            phase_cnt <= '0;
                            bit_idx   <= bit_idx + IW'(1);
                        end else begin
                            phase_cnt <= phase_cnt + CW'(1);
                        end
                    end
                    DONE:    state <= enable ? WAIT : IDLE;
                    WAIT:    if (!enable) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pad_reader_multi.sv
// Bench for pad_reader_multi: an 8-bit and a 16-bit instance polled against a
// behavioural pad model (shifts on pad_clk rise, reloads on latch) and edge-detect reference.
module tb_pad_reader_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en8 = 1'b0, en16 = 1'b0;
    logic [1:0]  data8 = 2'b11, data16 = 2'b11;
    logic        latch8, pclk8, val8, latch16, pclk16, val16;
    logic [15:0] btn8, prs8, rel8;
    logic [31:0] btn16, prs16, rel16;

    bit          sel = 1'b0;
    logic        latch_m, pclk_m, valid_m;
    logic [31:0] btn_m, prs_m, rel_m;
    logic [31:0] old_btn [2];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int last_rise = 0;
    int en_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pad_reader_multi #(.NUM_PADS(2), .NUM_BITS(8), .LATCH_CYCLES(4), .HALF_CYCLES(2),
                       .POLL_CYCLES(100)) dut8 (
        .clk(clk), .reset(rst), .enable(en8), .data(data8), .latch(latch8), .pad_clk(pclk8),
        .buttons(btn8), .pressed(prs8), .released(rel8), .valid(val8));

    pad_reader_multi #(.NUM_PADS(2), .NUM_BITS(16), .LATCH_CYCLES(4), .HALF_CYCLES(2),
                       .POLL_CYCLES(100)) dut16 (
        .clk(clk), .reset(rst), .enable(en16), .data(data16), .latch(latch16), .pad_clk(pclk16),
        .buttons(btn16), .pressed(prs16), .released(rel16), .valid(val16));

    assign latch_m = sel ? latch16 : latch8;
    assign pclk_m  = sel ? pclk16  : pclk8;
    assign valid_m = sel ? val16   : val8;
    assign btn_m   = sel ? btn16   : {16'h0, btn8};
    assign prs_m   = sel ? prs16   : {16'h0, prs8};
    assign rel_m   = sel ? rel16   : {16'h0, rel8};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_en(input logic v);
        if (sel) en16 = v; else en8 = v;
    endtask

    task automatic drive(input logic [15:0] p0, input logic [15:0] p1, input int pulses);
        int nb, bi;
        nb = sel ? 16 : 8;
        bi = (pulses > nb - 1) ? nb - 1 : pulses;
        if (sel) data16 = ~{p1[bi], p0[bi]};
        else     data8  = ~{p1[bi], p0[bi]};
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_strobes"}, {29'h0, latch_m, pclk_m, valid_m}, 32'h0);
        chk({tag, "_vectors"}, btn_m | prs_m | rel_m, 32'h0);
    endtask

    // Acts as the pads for one frame and checks waveform timing and the published result.
    task automatic run_frame(input logic [15:0] p0, input logic [15:0] p1,
                             input bit drop_en, input bit poll_chk);
        int nb, n, lat_n, hi_n, lo_n, pulses, bad_hi, bad_lo, bad_lat;
        logic [31:0] exp, old;
        logic prev_clk;
        nb = sel ? 16 : 8;
        n = 0;
        while (latch_m !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("latch_seen", {31'h0, latch_m}, 32'h1);
        if (latch_m !== 1'b1) return;
        rise_cyc = cyc;
        if (poll_chk) chk("poll_period", rise_cyc - last_rise, 32'd100);
        last_rise = rise_cyc;
        if (drop_en) set_en(1'b0);
        old = old_btn[sel];
        lat_n = 0;
        while (latch_m === 1'b1 && lat_n < 50) begin
            drive(p0, p1, 0);
            @(negedge clk);
            lat_n++;
        end
        chk("latch_width", lat_n, 32'd4);
        chk("buttons_hold", btn_m, old);
        pulses = 0; hi_n = 0; lo_n = 0; bad_hi = 0; bad_lo = 0; bad_lat = 0;
        prev_clk = 1'b0;
        n = 0;
        while (valid_m !== 1'b1 && n < 200) begin
            if (pclk_m && !prev_clk) begin
                pulses++;
                if (lo_n != 2) bad_lo++;
                lo_n = 0;
                hi_n = 0;
            end
            if (!pclk_m && prev_clk) begin
                if (hi_n != 2) bad_hi++;
                hi_n = 0;
                lo_n = 0;
            end
            if (pclk_m) hi_n++; else lo_n++;
            if (latch_m) bad_lat++;
            prev_clk = pclk_m;
            drive(p0, p1, pulses);
            @(negedge clk);
            n++;
        end
        chk("valid_seen", {31'h0, valid_m}, 32'h1);
        chk("pulse_count", pulses, nb - 1);
        chk("high_width_errs", bad_hi, 32'd0);
        chk("low_width_errs", bad_lo, 32'd0);
        chk("last_low_plus_done", lo_n, 32'd3);
        chk("latch_in_frame", bad_lat, 32'd0);
        exp = sel ? {p1, p0} : {16'h0, p1[7:0], p0[7:0]};
        chk("buttons", btn_m, exp);
        chk("pressed", prs_m, exp & ~old);
        chk("released", rel_m, ~exp & old);
        old_btn[sel] = exp;
        @(negedge clk);
        chk("pulses_cleared", {29'h0, valid_m, |prs_m, |rel_m}, 32'h0);
        chk("buttons_kept", btn_m, exp);
    endtask

    task automatic quiet_window(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (latch_m !== 1'b0 || valid_m !== 1'b0) hits++;
        end
        chk(tag, hits, 32'd0);
    endtask

    initial begin
        int pulses;
        int n;
        logic prev_clk;
        old_btn[0] = '0;
        old_btn[1] = '0;

        // Reset state and idling until enable is seen.
        @(negedge clk);
        chk_quiet("in_reset");
        @(negedge clk);
        rst = 1'b0;
        quiet_window("idle_after_reset", 5);
        chk_quiet("idle_outputs");

        // First frame: latch one edge after enable, pad0 bits 0 and 3 pressed.
        en_cyc = cyc;
        en8 = 1'b1;
        run_frame(16'h0009, 16'h0000, 1'b0, 1'b0);
        chk("latch_delay", rise_cyc - en_cyc, 32'd1);
        run_frame(16'h0009, 16'h0000, 1'b0, 1'b1);
        run_frame(16'h0008, 16'h0000, 1'b0, 1'b1);
        run_frame(16'h0008, 16'h00FF, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            run_frame(16'($urandom), 16'($urandom), 1'b0, 1'b1);
        end

        // Enable dropped in WAIT: back to IDLE, restart does not wait for the poll counter.
        en8 = 1'b0;
        quiet_window("wait_to_idle", 10);
        en_cyc = cyc;
        en8 = 1'b1;
        run_frame(16'($urandom), 16'($urandom), 1'b0, 1'b0);
        chk("restart_delay", rise_cyc - en_cyc, 32'd1);

        // Reset during HIGH of bit 4 aborts the frame.
        n = 0;
        while (latch_m !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        pulses = 0;
        prev_clk = 1'b0;
        n = 0;
        while (pulses < 5 && n < 300) begin
            @(negedge clk);
            if (pclk_m && !prev_clk) pulses++;
            prev_clk = pclk_m;
            n++;
        end
        chk("reached_bit4_high", {31'h0, pclk_m}, 32'h1);
        rst = 1'b1;
        en8 = 1'b0;
        #1;
        chk_quiet("async_reset");
        old_btn[0] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        quiet_window("no_latch_after_reset", 20);
        en_cyc = cyc;
        en8 = 1'b1;
        run_frame(16'h00A5, 16'h003C, 1'b0, 1'b0);
        chk("post_reset_delay", rise_cyc - en_cyc, 32'd1);

        // Enable dropped during LATCH: frame completes, then no further latch.
        run_frame(16'($urandom), 16'($urandom), 1'b1, 1'b1);
        quiet_window("stopped_8", 200);

        // 16-bit instance.
        sel = 1'b1;
        en_cyc = cyc;
        en16 = 1'b1;
        run_frame(16'h8001, 16'hFFFF, 1'b0, 1'b0);
        chk("latch_delay_16", rise_cyc - en_cyc, 32'd1);
        for (int k = 0; k < 2; k++) begin
            run_frame(16'($urandom), 16'($urandom), 1'b0, 1'b1);
        end
        run_frame(16'($urandom), 16'($urandom), 1'b1, 1'b1);
        quiet_window("stopped_16", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
